// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester, grant and FIFO-write signals shared by the arbiter
// and its environment. The slave modport is the arbiter's view of the bundle.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        accept;
  logic                    fifo_full;
  logic                    fifo_wr_en;
  logic [DATA_W-1:0]       fifo_data_in;
  logic                    busy;

  // Requesters and FIFO side: drives requests, data and the full flag.
  modport master (
    output req, req_data, fifo_full,
    input  gnt, accept, fifo_wr_en, fifo_data_in, busy
  );

  // Arbiter side: samples requests, produces grant and FIFO write port.
  modport slave (
    input  req, req_data, fifo_full,
    output gnt, accept, fifo_wr_en, fifo_data_in, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a shared synchronous FIFO.
// A winner holds the grant for up to BURST_MAX writes or until it drops its
// request; an FIFO-full stall freezes the tenure without releasing it. One
// IDLE arbitration cycle always separates consecutive tenures.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic [PTR_W-1:0] winner;
  logic [N_REQ-1:0] gnt_q, gnt_nxt;
  logic [3:0]       burst_cnt, burst_cnt_nxt;
  logic             owner_req;
  logic             wr_en;
  logic             burst_done;

  // Round-robin search: first set request at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    winner = rr_ptr;
    idx    = 0;
    // Walk downward so the last hit kept is the closest one above rr_ptr.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (bus.req[idx]) winner = idx[PTR_W-1:0];
    end
  end

  assign owner_req  = bus.req[owner];
  assign wr_en      = (state == BUSY) && owner_req && !bus.fifo_full;
  assign burst_done = wr_en && ((burst_cnt + 4'd1) == 4'(BURST_MAX));

  // Next-state logic: grant on any request in IDLE, release on burst end or request drop.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    gnt_nxt       = gnt_q;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt       = BUSY;
          owner_nxt       = winner;
          gnt_nxt         = '0;
          gnt_nxt[winner] = 1'b1;
          burst_cnt_nxt   = 4'd0;
        end
      end
      BUSY: begin
        if (wr_en) burst_cnt_nxt = burst_cnt + 4'd1;
        if (!owner_req || burst_done) begin
          state_nxt  = IDLE;
          gnt_nxt    = '0;
          rr_ptr_nxt = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous reset; reset aborts any tenure in progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      gnt_q     <= '0;
      burst_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      gnt_q     <= gnt_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.busy         = (state == BUSY);
  assign bus.fifo_wr_en   = wr_en;
  // gnt_q is one-hot at the owner while busy, so it doubles as the accept mask.
  assign bus.accept       = wr_en ? gnt_q : '0;
  assign bus.fifo_data_in = (state == BUSY) ? bus.req_data[int'(owner)*DATA_W +: DATA_W]
                                            : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: single grant, full rotation, FIFO-full
// stall, mid-burst reset, drop-while-full and repeated single-requester bursts.
module tb_fifo_wr_arbiter;

  localparam int N_REQ     = 4;
  localparam int DATA_W    = 8;
  localparam int BURST_MAX = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [DATA_W-1:0] exp_data [N_REQ];

  fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  fifo_wr_arbiter #(
    .N_REQ    (N_REQ),
    .DATA_W   (DATA_W),
    .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_data(input int i, input logic [DATA_W-1:0] v);
    exp_data[i] = v;
    bus.req_data[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic check_write(input string tag, input int o);
    logic [N_REQ-1:0] one;
    one = '0;
    one[o] = 1'b1;
    check({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 32'd1);
    check({tag, "_data"},  32'(bus.fifo_data_in), 32'(exp_data[o]));
    check({tag, "_accept"}, 32'(bus.accept), 32'(one));
  endtask

  initial begin
    int order [5];
    int group_len [3];
    logic [N_REQ-1:0] one;
    order     = '{0, 1, 2, 3, 0};
    group_len = '{4, 4, 2};

    // Reset state
    rst = 1'b1;
    bus.req = '0;
    bus.fifo_full = 1'b0;
    bus.req_data = '0;
    set_data(0, 8'hA0);
    set_data(1, 8'hB1);
    set_data(2, 8'hC2);
    set_data(3, 8'hD3);
    tick;
    tick;
    check("rst_gnt",    32'(bus.gnt), 32'd0);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_wr_en",  32'(bus.fifo_wr_en), 32'd0);
    check("rst_accept", 32'(bus.accept), 32'd0);
    check("rst_data",   32'(bus.fifo_data_in), 32'd0);
    rst = 1'b0;
    tick;
    check("idle_hold_gnt", 32'(bus.gnt), 32'd0);

    // Single requester 2, three words then request drop
    set_data(2, 8'hA1);
    bus.req = 4'b0100;
    settle;
    check("t1_pre_gnt", 32'(bus.gnt), 32'd0);
    tick;
    check("t1_gnt",  32'(bus.gnt), 32'b0100);
    check("t1_busy", 32'(bus.busy), 32'd1);
    check_write("t1_w1", 2);
    tick;
    set_data(2, 8'hA2);
    settle;
    check_write("t1_w2", 2);
    tick;
    set_data(2, 8'hA3);
    settle;
    check_write("t1_w3", 2);
    tick;
    bus.req = '0;
    settle;
    check("t1_drop_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    check("t1_drop_busy",  32'(bus.busy), 32'd1);
    tick;
    check("t1_rel_gnt",  32'(bus.gnt), 32'd0);
    check("t1_rel_busy", 32'(bus.busy), 32'd0);
    // rr_ptr must now be 3: requests 0 and 3 together go to 3
    bus.req = 4'b1001;
    tick;
    check("t1_rr_ptr3_gnt", 32'(bus.gnt), 32'b1000);
    bus.req = '0;
    settle;
    check("t1_rr_ptr3_no_wr", 32'(bus.fifo_wr_en), 32'd0);
    tick;
    check("t1_rr_ptr3_rel", 32'(bus.gnt), 32'd0);
    set_data(2, 8'hC2);

    // All requesting: tenures 0,1,2,3,0 with four writes and one idle cycle each
    bus.req = 4'b1111;
    foreach (order[k]) begin
      one = '0;
      one[order[k]] = 1'b1;
      tick;
      check("t2_gnt", 32'(bus.gnt), 32'(one));
      for (int w = 0; w < BURST_MAX; w++) begin
        check_write("t2_w", order[k]);
        tick;
      end
      check("t2_idle_busy", 32'(bus.busy), 32'd0);
      check("t2_idle_gnt",  32'(bus.gnt), 32'd0);
    end

    // Requester 1 stalled by FIFO full after its second write
    bus.req = 4'b0010;
    tick;
    check("t3_gnt", 32'(bus.gnt), 32'b0010);
    for (int w = 0; w < 2; w++) begin
      check_write("t3_pre", 1);
      tick;
    end
    bus.fifo_full = 1'b1;
    settle;
    for (int s = 0; s < 3; s++) begin
      check("t3_stall_wr_en",  32'(bus.fifo_wr_en), 32'd0);
      check("t3_stall_accept", 32'(bus.accept), 32'd0);
      check("t3_stall_gnt",    32'(bus.gnt), 32'b0010);
      tick;
    end
    bus.fifo_full = 1'b0;
    settle;
    for (int w = 0; w < 2; w++) begin
      check_write("t3_post", 1);
      tick;
    end
    check("t3_rel_gnt",  32'(bus.gnt), 32'd0);
    check("t3_rel_busy", 32'(bus.busy), 32'd0);

    // Reset in the middle of requester 2's burst
    bus.req = 4'b0110;
    tick;
    check("t4_gnt", 32'(bus.gnt), 32'b0100);
    check_write("t4_w1", 2);
    tick;
    check_write("t4_w2", 2);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    settle;
    check("t4_rst_gnt",    32'(bus.gnt), 32'd0);
    check("t4_rst_busy",   32'(bus.busy), 32'd0);
    check("t4_rst_wr_en",  32'(bus.fifo_wr_en), 32'd0);
    check("t4_rst_accept", 32'(bus.accept), 32'd0);
    check("t4_rst_data",   32'(bus.fifo_data_in), 32'd0);
    tick;
    check("t4_regrant", 32'(bus.gnt), 32'b0010);

    // Owner drops request while FIFO is full: release without a write
    bus.req = '0;
    bus.fifo_full = 1'b1;
    settle;
    check("t5_wr_en",  32'(bus.fifo_wr_en), 32'd0);
    check("t5_accept", 32'(bus.accept), 32'd0);
    tick;
    check("t5_rel_gnt",  32'(bus.gnt), 32'd0);
    check("t5_rel_busy", 32'(bus.busy), 32'd0);
    // rr_ptr advanced to 2: requests 1 and 2 together go to 2
    bus.req = 4'b0110;
    bus.fifo_full = 1'b0;
    tick;
    check("t5_rr_ptr_gnt", 32'(bus.gnt), 32'b0100);
    bus.req = '0;
    settle;
    check("t5_drop_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    tick;
    check("t5_drop_gnt", 32'(bus.gnt), 32'd0);

    // Lone requester 3 with ten words: groups of 4, 4 and 2
    bus.req = 4'b1000;
    foreach (group_len[g]) begin
      tick;
      check("t6_gnt", 32'(bus.gnt), 32'b1000);
      for (int w = 0; w < group_len[g]; w++) begin
        check_write("t6_w", 3);
        tick;
      end
      if (g == 2) begin
        bus.req = '0;
        settle;
        check("t6_drop_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        tick;
      end
      check("t6_idle_gnt",  32'(bus.gnt), 32'd0);
      check("t6_idle_busy", 32'(bus.busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
